// File: rtl/fpadd_pkg.sv
// rtl/fpadd_pkg.sv - shared states, width helpers and result constructors for fp_addsub_pipe
package fpadd_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_ALIGN = 3'd1;
    localparam state_t ST_ADD   = 3'd2;
    localparam state_t ST_NORM  = 3'd3;
    localparam state_t ST_ROUND = 3'd4;
    localparam state_t ST_DONE  = 3'd5;

    // Exponent bias for a given exponent field width.
    function automatic int exp_bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    // Working significand: hidden 1, stored mantissa, then guard, round, sticky.
    function automatic int sig_width(input int man_w);
        return man_w + 4;
    endfunction

    // Saturated overflow value {sign, all-ones exponent, all-ones mantissa}, right-aligned.
    function automatic logic [63:0] sat_result(input logic sign, input int exp_w, input int man_w);
        logic [63:0] v_mag;
        logic [63:0] v_sgn;
        v_mag = (64'd1 << (exp_w + man_w)) - 64'd1;
        v_sgn = {63'd0, sign} << (exp_w + man_w);
        return v_mag | v_sgn;
    endfunction

    // Signed zero {sign, zeros}, right-aligned.
    function automatic logic [63:0] zero_result(input logic sign, input int exp_w, input int man_w);
        return {63'd0, sign} << (exp_w + man_w);
    endfunction

endpackage

// File: rtl/fpadd_align_shift.sv
// rtl/fpadd_align_shift.sv - combinational right barrel shifter folding shifted-out bits into sticky
module fpadd_align_shift #(
    parameter int SIG_W = 7,
    parameter int SH_W  = 4
) (
    input  logic [SIG_W-1:0] i_sig,
    input  logic [SH_W-1:0]  i_shamt,
    output logic [SIG_W-1:0] o_sig
);

    logic [SIG_W-1:0] w_shifted;
    logic             w_sticky;
    int               w_sh_int;

    // Shift right and OR every bit that falls off the bottom into bit 0.
    always_comb begin
        w_sh_int = 32'(i_shamt);
        w_sticky = 1'b0;
        for (int i = 0; i < SIG_W; i++) begin
            if (i < w_sh_int) begin
                w_sticky = w_sticky | i_sig[i];
            end
        end
        if (w_sh_int >= SIG_W) begin
            w_shifted = '0;
        end else begin
            w_shifted = i_sig >> i_shamt;
        end
        o_sig = w_shifted | {{(SIG_W-1){1'b0}}, w_sticky};
    end

endmodule

// File: rtl/fp_addsub_pipe.sv
// rtl/fp_addsub_pipe.sv - multi-cycle FSM floating-point add/sub; FPADD_RNE_EN selects round-to-nearest-even over truncation
module fp_addsub_pipe
    import fpadd_pkg::*;
#(
    parameter  int EXP_W = 4,
    parameter  int MAN_W = 3,
    localparam int W     = 1 + EXP_W + MAN_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         op,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] result,
    output logic         ovf,
    output logic         unf,
    output logic         zero
);

    localparam int               SW       = sig_width(MAN_W);
    localparam logic [EXP_W-1:0] EXP_ONES = '1;

    state_t           r_state;
    logic [W-1:0]     r_a;
    logic [W-1:0]     r_b;          // sign already folded with op
    logic [SW-1:0]    r_sig_l;
    logic [SW-1:0]    r_sig_s;
    logic [SW:0]      r_sum;        // top bit is the adder carry
    logic [EXP_W-1:0] r_exp;
    logic             r_sign;
    logic             r_sub;
    logic [W-1:0]     r_result;
    logic             r_ovf;
    logic             r_unf;
    logic             r_zero;

    logic             w_a_big;
    logic [W-1:0]     w_big;
    logic [W-1:0]     w_small;
    logic [EXP_W-1:0] w_exp_l;
    logic [EXP_W-1:0] w_exp_s;
    logic [EXP_W-1:0] w_shamt;
    logic [SW-1:0]    w_sig_l;
    logic [SW-1:0]    w_sig_s_raw;
    logic [SW-1:0]    w_sig_s;
    logic [SW:0]      w_sum;
    logic [EXP_W:0]   w_exp_inc;
    logic [EXP_W-1:0] w_exp_dec;
    logic [MAN_W-1:0] w_man;
    logic             w_inc;
    logic [MAN_W+1:0] w_rnd;
    logic [MAN_W-1:0] w_rnd_man;
    logic [EXP_W:0]   w_rnd_exp;
    logic             w_rnd_ovf;

    // Magnitude ordering (exponent, then mantissa; ties pick B) and unshifted significands.
    always_comb begin
        w_a_big     = r_a[W-2:0] > r_b[W-2:0];
        w_big       = w_a_big ? r_a : r_b;
        w_small     = w_a_big ? r_b : r_a;
        w_exp_l     = w_big[W-2:MAN_W];
        w_exp_s     = w_small[W-2:MAN_W];
        w_shamt     = w_exp_l - w_exp_s;
        w_sig_l     = (w_exp_l == '0) ? '0 : {1'b1, w_big[MAN_W-1:0], 3'b000};
        w_sig_s_raw = (w_exp_s == '0) ? '0 : {1'b1, w_small[MAN_W-1:0], 3'b000};
    end

    fpadd_align_shift #(
        .SIG_W (SW),
        .SH_W  (EXP_W)
    ) u_align_shift (
        .i_sig   (w_sig_s_raw),
        .i_shamt (w_shamt),
        .o_sig   (w_sig_s)
    );

    // Add or subtract; the larger magnitude is always r_sig_l so subtraction never goes negative.
    always_comb begin
        if (r_sub) begin
            w_sum = {1'b0, r_sig_l} - {1'b0, r_sig_s};
        end else begin
            w_sum = {1'b0, r_sig_l} + {1'b0, r_sig_s};
        end
        w_exp_inc = {1'b0, r_exp} + (EXP_W+1)'(1);
        w_exp_dec = r_exp - EXP_W'(1);
    end

    // Rounding increment on the normalised significand, with mantissa carry-out folded into the exponent.
    always_comb begin
        w_man = r_sum[SW-2:3];
`ifdef FPADD_RNE_EN
        w_inc = r_sum[2] & (r_sum[1] | r_sum[0] | r_sum[3]);
`else
        w_inc = 1'b0;
`endif
        w_rnd     = {2'b01, w_man} + {{(MAN_W+1){1'b0}}, w_inc};
        w_rnd_man = w_rnd[MAN_W+1] ? w_rnd[MAN_W:1] : w_rnd[MAN_W-1:0];
        w_rnd_exp = {1'b0, r_exp} + {{EXP_W{1'b0}}, w_rnd[MAN_W+1]};
        w_rnd_ovf = w_rnd_exp >= {1'b0, EXP_ONES};
    end

    // Control FSM and datapath registers; one operation in flight at a time.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_sig_l  <= '0;
            r_sig_s  <= '0;
            r_sum    <= '0;
            r_exp    <= '0;
            r_sign   <= 1'b0;
            r_sub    <= 1'b0;
            r_result <= '0;
            r_ovf    <= 1'b0;
            r_unf    <= 1'b0;
            r_zero   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_b     <= {b[W-1] ^ op, b[W-2:0]};
                        r_state <= ST_ALIGN;
                    end
                end
                ST_ALIGN: begin
                    r_sig_l <= w_sig_l;
                    r_sig_s <= w_sig_s;
                    r_exp   <= w_exp_l;
                    r_sign  <= w_big[W-1];
                    r_sub   <= w_big[W-1] ^ w_small[W-1];
                    r_state <= ST_ADD;
                end
                ST_ADD: begin
                    if (w_sum == '0) begin
                        r_result <= W'(zero_result(1'b0, EXP_W, MAN_W));
                        r_zero   <= 1'b1;
                        r_state  <= ST_DONE;
                    end else begin
                        r_sum   <= w_sum;
                        r_state <= ST_NORM;
                    end
                end
                ST_NORM: begin
                    if (r_sum[SW]) begin
                        if (w_exp_inc >= {1'b0, EXP_ONES}) begin
                            r_result <= W'(sat_result(r_sign, EXP_W, MAN_W));
                            r_ovf    <= 1'b1;
                            r_state  <= ST_DONE;
                        end else begin
                            r_sum   <= {1'b0, r_sum[SW:2], r_sum[1] | r_sum[0]};
                            r_exp   <= w_exp_inc[EXP_W-1:0];
                            r_state <= ST_ROUND;
                        end
                    end else if (!r_sum[SW-1]) begin
                        if (w_exp_dec == '0) begin
                            r_result <= W'(zero_result(r_sign, EXP_W, MAN_W));
                            r_unf    <= 1'b1;
                            r_zero   <= 1'b1;
                            r_state  <= ST_DONE;
                        end else begin
                            r_sum   <= {r_sum[SW-1:0], 1'b0};
                            r_exp   <= w_exp_dec;
                            // The bit below the hidden position becomes the hidden bit after this shift.
                            r_state <= r_sum[SW-2] ? ST_ROUND : ST_NORM;
                        end
                    end else begin
                        r_state <= ST_ROUND;
                    end
                end
                ST_ROUND: begin
                    if (w_rnd_ovf) begin
                        r_result <= W'(sat_result(r_sign, EXP_W, MAN_W));
                        r_ovf    <= 1'b1;
                    end else begin
                        r_result <= {r_sign, w_rnd_exp[EXP_W-1:0], w_rnd_man};
                    end
                    r_state <= ST_DONE;
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_ovf   <= 1'b0;
                        r_unf   <= 1'b0;
                        r_zero  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign result    = r_result;
    assign ovf       = r_ovf;
    assign unf       = r_unf;
    assign zero      = r_zero;

endmodule
